// File: rtl/div_result_bcd.sv
// Binary-to-packed-BCD converter for divider results.
// Sequential double-dabble, one bit per cycle, with a valid/ready handshake on both sides.
module div_result_bcd #(
    parameter  int WIDTH  = 32,
    parameter  int DIGITS = 10,
    localparam int CNTW   = $clog2(WIDTH + 1),
    localparam int NDW    = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [NDW-1:0]        ndigits
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      shift_bin;
    logic [4*DIGITS-1:0]   bcd_acc;
    logic [CNTW-1:0]       cnt;
    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   bcd_shifted;
    logic [WIDTH-1:0]      bin_shifted;
    logic [NDW-1:0]        nd_next;
    logic                  last_shift;

    assign last_shift = (cnt == CNTW'(WIDTH - 1));
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    always_comb begin
        adjusted = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // The combined {bcd,bin} register rotates rather than shifts; the bit that wraps
    // into the binary LSB is always zero because the result cannot overflow DIGITS.
    assign bcd_shifted = {adjusted[4*DIGITS-2:0], shift_bin[WIDTH-1]};
    assign bin_shifted = {shift_bin[WIDTH-2:0], adjusted[4*DIGITS-1]};

    always_comb begin
        nd_next = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shifted[4*i +: 4] != 4'd0) begin
                nd_next = NDW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_bin <= '0;
            bcd_acc   <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            ndigits   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_bin <= bin_in;
                        bcd_acc   <= '0;
                        cnt       <= '0;
                    end
                end
                SHIFT: begin
                    bcd_acc   <= bcd_shifted;
                    shift_bin <= bin_shifted;
                    cnt       <= cnt + CNTW'(1);
                    if (last_shift) begin
                        bcd_out <= bcd_shifted;
                        ndigits <= nd_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed corner values plus random values
// compared against a decimal-arithmetic reference model.
module tb_div_result_bcd;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   bin_in;
    logic          out_valid;
    logic          out_ready;
    logic [39:0]   bcd_out;
    logic [3:0]    ndigits;

    int vectors     = 0;
    int miscompares = 0;

    div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ndigits   (ndigits)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] refBcd(input logic [31:0] value);
        longint unsigned v = value;
        logic [39:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] refDigits(input logic [31:0] value);
        longint unsigned v = value;
        int n = 0;
        while (v > 0) begin
            n++;
            v = v / 10;
        end
        return (n == 0) ? 4'd1 : 4'(n);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Starting at a negedge right after the capture edge, waits out the conversion and checks the result.
    task automatic waitResult(input logic [31:0] value);
        repeat (WIDTH - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("out_valid_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("out_valid_done", 64'(out_valid), 64'd1);
        checkOutput("in_ready_done", 64'(in_ready), 64'd0);
        checkOutput("bcd_out", 64'(bcd_out), 64'(refBcd(value)));
        checkOutput("ndigits", 64'(ndigits), 64'(refDigits(value)));
    endtask

    task automatic applyStimulus(input logic [31:0] value, input int hold_cycles);
        @(negedge clk);
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        bin_in   = value;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("in_ready_shift", 64'(in_ready), 64'd0);
        waitResult(value);
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_bcd", 64'(bcd_out), 64'(refBcd(value)));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_after_hs", 64'(out_valid), 64'd0);
        checkOutput("in_ready_after_hs", 64'(in_ready), 64'd1);
        checkOutput("bcd_kept_after_hs", 64'(bcd_out), 64'(refBcd(value)));
    endtask

    initial begin
        logic [31:0] r;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = '0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_bcd", 64'(bcd_out), 64'd0);
        checkOutput("reset_ndigits", 64'(ndigits), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        applyStimulus(32'd0, 0);
        applyStimulus(32'd12345, 0);
        applyStimulus(32'd1024, 0);
        applyStimulus(32'hFFFF_FFFF, 0);
        applyStimulus(32'd987654, 5);

        // New input presented throughout a conversion must wait for IDLE.
        @(negedge clk);
        in_valid = 1'b1;
        bin_in   = 32'd100;
        @(negedge clk);
        bin_in = 32'd7;
        waitResult(32'd100);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("skid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("skid_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("skid_captured", 64'(in_ready), 64'd0);
        waitResult(32'd7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a conversion.
        in_valid = 1'b1;
        bin_in   = 32'd99999;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_bcd", 64'(bcd_out), 64'd0);
        checkOutput("midreset_ndigits", 64'(ndigits), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(32'd3, 0);

        for (int n = 0; n < 10; n++) begin
            r = $urandom >> $urandom_range(0, 31);
            applyStimulus(r, n % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
